// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nco_pkg
//  Purpose  : Shared constants and elaboration-time helpers for the multi-
//             channel NCO: pipeline latency, configuration-select codes,
//             sine-table depth/content functions and dither LFSR constants.
//  Revision : 1.0  initial release
// ============================================================================
package nco_pkg;

    // Registered stages from accumulator sample to da_data.
    localparam int PIPE_LATENCY = 4;

    // cfg_sel encodings.
    localparam logic CFG_SEL_FCW = 1'b0;
    localparam logic CFG_SEL_OFF = 1'b1;

    // Galois LFSR for optional phase dither: x^16 + x^14 + x^13 + x^11 + 1,
    // right-shifting form (feedback mask applied when the LSB shifts out).
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Quarter-wave table holds entries 0..Q inclusive, Q = 2^(phase_w-2).
    function automatic int tbl_depth(input int phase_w);
        return (1 << (phase_w - 2)) + 1;
    endfunction

    // Width of the channel-select port (at least one bit).
    function automatic int ch_sel_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // round(amp * sin(pi*idx/(2*quarter))) for 0 <= idx <= quarter.
    // A Taylor series is used so the table is built without math-library
    // calls; 12 terms are far below one LSB of error over [0, pi/2].
    function automatic int sin_tbl_val(input int idx, input int quarter, input int amp);
        real x;
        real term;
        real sum;
        x    = 3.14159265358979323846 * real'(idx) / (2.0 * real'(quarter));
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return $rtoi(real'(amp) * sum + 0.5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nco_sin_lut.sv
`default_nettype none
// ============================================================================
//  Module   : nco_sin_lut
//  Purpose  : Quarter-wave sine lookup with quadrant mirroring, two
//             registered stages (quadrant/address, table read + sign).
//  Ports    : clk_i    - clock
//             rst_i    - async active-high reset
//             phase_i  - truncated phase {quadrant[1:0], index}
//             amp_o    - signed amplitude, two stages after phase_i
//  Revision : 1.0  initial release
// ============================================================================
module nco_sin_lut
    import nco_pkg::*;
#(
    parameter int PHASE_W = 10,
    parameter int OUT_W   = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [PHASE_W-1:0]       phase_i,
    output logic signed [OUT_W-1:0]  amp_o
);

    localparam int c_R_W   = PHASE_W - 2;
    localparam int c_QTR   = 1 << c_R_W;
    localparam int c_DEPTH = tbl_depth(PHASE_W);
    localparam int c_AMP   = (1 << (OUT_W - 1)) - 1;

    // Constant quarter-wave ROM, entries 0..Q inclusive.
    logic [OUT_W-2:0] w_tbl [c_DEPTH];

    for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_tbl
        localparam int c_VAL = sin_tbl_val(gi, c_QTR, c_AMP);
        assign w_tbl[gi] = (OUT_W-1)'(c_VAL);
    end

    logic [1:0]              w_quad;
    logic [c_R_W-1:0]        w_r;
    logic [c_R_W:0]          addr_d, addr_q;
    logic                    neg_d, neg_q;
    logic [OUT_W-2:0]        w_mag;
    logic signed [OUT_W-1:0] amp_d, amp_q;

    always_comb begin
        w_quad = phase_i[PHASE_W-1 -: 2];
        w_r    = phase_i[c_R_W-1:0];
        // Odd quadrants walk the quarter wave backwards (T[Q-r]); the extra
        // address bit lets r=0 reach the T[Q] peak entry.
        addr_d = w_quad[0] ? ((c_R_W+1)'(c_QTR) - {1'b0, w_r}) : {1'b0, w_r};
        // Lower half-cycle (quadrants 2,3) is the negated upper half.
        neg_d  = w_quad[1];
        w_mag  = w_tbl[addr_q];
        amp_d  = neg_q ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            neg_q  <= 1'b0;
            amp_q  <= '0;
        end else begin
            addr_q <= addr_d;
            neg_q  <= neg_d;
            amp_q  <= amp_d;
        end
    end

    assign amp_o = amp_q;

endmodule
`default_nettype wire

// File: rtl/multi_nco.sv
`default_nettype none
// ============================================================================
//  Module   : multi_nco
//  Purpose  : NUM_CH independent numerically-controlled oscillators with
//             shadowed FCW/phase-offset configuration, coherent restart and
//             a 4-stage pipeline to offset-binary DAC samples.
//  Config   : NCO_DITHER_EN - when defined, a per-channel 16-bit Galois LFSR
//             dithers the phase bits below truncation (latency unchanged).
//  Ports    : sys_clk    - sole clock
//             sys_rst    - async active-high reset
//             en         - advance accumulators, launch a sample
//             sync_clr   - zero all accumulators on the next edge
//             cfg_wr     - write cfg_data into shadow[cfg_ch][cfg_sel]
//             cfg_ch     - target channel (out-of-range writes ignored)
//             cfg_sel    - 0 = FCW, 1 = phase offset
//             cfg_data   - shadow write data
//             cfg_commit - copy all shadows to active registers
//             da_data    - channel k at [k*OUT_W +: OUT_W], offset binary
//             out_valid  - da_data holds a freshly launched sample
//  Revision : 1.0  initial release
// ============================================================================
module multi_nco
    import nco_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 10,
    parameter int OUT_W   = 8
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        en,
    input  logic                        sync_clr,
    input  logic                        cfg_wr,
    input  logic [ch_sel_w(NUM_CH)-1:0] cfg_ch,
    input  logic                        cfg_sel,
    input  logic [ACC_W-1:0]            cfg_data,
    input  logic                        cfg_commit,
    output logic [NUM_CH*OUT_W-1:0]     da_data,
    output logic                        out_valid
);

    localparam logic [OUT_W-1:0] c_MID = {1'b1, {(OUT_W-1){1'b0}}};

    // Launch tracker: bit 0 aligns with the phase register, the top bit with
    // da_data. It shifts every cycle so in-flight samples drain after en drops.
    logic [PIPE_LATENCY-1:0] vld_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[PIPE_LATENCY-2:0], en};
        end
    end

    assign out_valid = vld_q[PIPE_LATENCY-1];

    for (genvar gk = 0; gk < NUM_CH; gk++) begin : g_ch
        logic [ACC_W-1:0]        acc_q, acc_d;
        logic [ACC_W-1:0]        fcw_sh_q, off_sh_q;
        logic [ACC_W-1:0]        fcw_act_q, off_act_q;
        logic [PHASE_W-1:0]      phase_q, phase_d;
        logic [OUT_W-1:0]        da_q;
        logic signed [OUT_W-1:0] w_amp;
        logic                    w_wr_this;

        assign w_wr_this = cfg_wr && (int'(cfg_ch) == gk);

        always_comb begin
            acc_d = acc_q;
            if (sync_clr) begin
                acc_d = '0;
            end else if (en) begin
                acc_d = acc_q + fcw_act_q;
            end
        end

`ifdef NCO_DITHER_EN
        logic [15:0]      lfsr_q;
        logic [ACC_W-1:0] w_dith;

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                lfsr_q <= LFSR_SEED ^ 16'(gk);
            end else if (en) begin
                lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
            end
        end

        // LFSR MSB lands just below the truncation point.
        assign w_dith  = ACC_W'({lfsr_q, {ACC_W{1'b0}}} >> (PHASE_W + 16));
        assign phase_d = PHASE_W'((acc_q + off_act_q + w_dith) >> (ACC_W - PHASE_W));
`else
        // Phase uses the pre-increment accumulator value.
        assign phase_d = PHASE_W'((acc_q + off_act_q) >> (ACC_W - PHASE_W));
`endif

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                acc_q     <= '0;
                fcw_sh_q  <= '0;
                off_sh_q  <= '0;
                fcw_act_q <= '0;
                off_act_q <= '0;
                phase_q   <= '0;
                da_q      <= c_MID;
            end else begin
                acc_q <= acc_d;
                if (en) begin
                    phase_q <= phase_d;
                end
                // Commit reads the shadow before any same-cycle write lands.
                if (cfg_commit) begin
                    fcw_act_q <= fcw_sh_q;
                    off_act_q <= off_sh_q;
                end
                if (w_wr_this && (cfg_sel == CFG_SEL_FCW)) begin
                    fcw_sh_q <= cfg_data;
                end
                if (w_wr_this && (cfg_sel == CFG_SEL_OFF)) begin
                    off_sh_q <= cfg_data;
                end
                // Offset binary: adding 2^(OUT_W-1) just flips the sign bit.
                if (vld_q[PIPE_LATENCY-2]) begin
                    da_q <= {~w_amp[OUT_W-1], w_amp[OUT_W-2:0]};
                end
            end
        end

        nco_sin_lut #(
            .PHASE_W (PHASE_W),
            .OUT_W   (OUT_W)
        ) u_lut (
            .clk_i   (sys_clk),
            .rst_i   (sys_rst),
            .phase_i (phase_q),
            .amp_o   (w_amp)
        );

        assign da_data[gk*OUT_W +: OUT_W] = da_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_nco.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_nco
//  Purpose  : Self-checking bench for multi_nco (NUM_CH=2, ACC_W=32,
//             PHASE_W=10, OUT_W=8, dither disabled). A behavioural model
//             computes each sample as round(127*sin(2*pi*p/1024)) + 128 and
//             delays it by the pipeline latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_nco;

    logic        sys_clk    = 1'b0;
    logic        sys_rst    = 1'b1;
    logic        en         = 1'b0;
    logic        sync_clr   = 1'b0;
    logic        cfg_wr     = 1'b0;
    logic [0:0]  cfg_ch     = 1'b0;
    logic        cfg_sel    = 1'b0;
    logic [31:0] cfg_data   = 32'h0;
    logic        cfg_commit = 1'b0;
    logic [15:0] da_data;
    logic        out_valid;

    multi_nco #(
        .NUM_CH  (2),
        .ACC_W   (32),
        .PHASE_W (10),
        .OUT_W   (8)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .en         (en),
        .sync_clr   (sync_clr),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_sel    (cfg_sel),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .da_data    (da_data),
        .out_valid  (out_valid)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        int d0;
        int d1;
    } ent_t;

    bit [31:0] m_acc    [2];
    bit [31:0] m_fcw    [2];
    bit [31:0] m_off    [2];
    bit [31:0] m_fcw_sh [2];
    bit [31:0] m_off_sh [2];
    ent_t      pipe [$];
    bit        exp_v;
    int        exp_d [2];

    function automatic int ref_sample(input bit [31:0] ph);
        int  p;
        real x;
        int  s;
        p = int'(ph >> 22);
        x = 127.0 * $sin(2.0 * 3.14159265358979323846 * real'(p) / 1024.0);
        s = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        return 128 + s;
    endfunction

    task automatic model_reset();
        ent_t e;
        for (int c = 0; c < 2; c++) begin
            m_acc[c] = 0; m_fcw[c] = 0; m_off[c] = 0;
            m_fcw_sh[c] = 0; m_off_sh[c] = 0;
            exp_d[c] = 128;
        end
        exp_v = 1'b0;
        pipe.delete();
        e.v = 1'b0; e.d0 = 0; e.d1 = 0;
        // A sample entering at edge k leaves at edge k+3 (visible in cycle 4).
        repeat (3) pipe.push_back(e);
    endtask

    task automatic model_edge();
        ent_t e;
        ent_t f;
        if (sys_rst) begin
            model_reset();
            return;
        end
        e.v  = en;
        e.d0 = ref_sample(m_acc[0] + m_off[0]);
        e.d1 = ref_sample(m_acc[1] + m_off[1]);
        pipe.push_back(e);
        f = pipe.pop_front();
        exp_v = f.v;
        if (f.v) begin
            exp_d[0] = f.d0;
            exp_d[1] = f.d1;
        end
        for (int c = 0; c < 2; c++) begin
            if (sync_clr)  m_acc[c] = 0;
            else if (en)   m_acc[c] = m_acc[c] + m_fcw[c];
            if (cfg_commit) begin
                m_fcw[c] = m_fcw_sh[c];
                m_off[c] = m_off_sh[c];
            end
        end
        if (cfg_wr) begin
            if (cfg_sel) m_off_sh[cfg_ch] = cfg_data;
            else         m_fcw_sh[cfg_ch] = cfg_data;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_edge();
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
        chk("da_ch0", {24'b0, da_data[7:0]},  exp_d[0]);
        chk("da_ch1", {24'b0, da_data[15:8]}, exp_d[1]);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic cfg(input bit ch, input bit sel, input bit [31:0] d);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    logic [7:0] rec [512];
    logic [7:0] x0, x1;

    initial begin
        model_reset();

        // Reset state.
        run(2);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_da", {16'b0, da_data}, 32'h8080);
        sys_rst = 1'b0;
        run(2);

        // FCW=0, offset=0: first out_valid exactly in cycle 4, constant 128.
        en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("lat_valid", {31'b0, out_valid}, (i == 4) ? 32'd1 : 32'd0);
        end
        run(6);
        chk("zero_fcw_da", {16'b0, da_data}, 32'h8080);

        // Quarter / three-quarter phase offsets.
        cfg(1'b0, 1'b1, 32'h4000_0000);
        cfg(1'b1, 1'b1, 32'hC000_0000);
        run(3);
        chk("no_commit_da", {16'b0, da_data}, 32'h8080);
        commit();
        run(6);
        chk("off_ch0_peak", {24'b0, da_data[7:0]}, 32'd255);
        chk("off_ch1_trough", {24'b0, da_data[15:8]}, 32'd1);

        // Nyquist FCW: two-sample alternation on ch0.
        cfg(1'b0, 1'b0, 32'h8000_0000);
        commit();
        run(6);
        tick(); x0 = da_data[7:0];
        tick(); x1 = da_data[7:0];
        chk("nyq_alt", {31'b0, ((x0 == 8'd255 && x1 == 8'd1) || (x0 == 8'd1 && x1 == 8'd255))}, 32'd1);

        // 256-sample period, exact repeat.
        cfg(1'b0, 1'b0, 32'h0100_0000);
        cfg(1'b0, 1'b1, 32'h0000_0000);
        commit();
        run(6);
        for (int i = 0; i < 512; i++) begin
            tick();
            rec[i] = da_data[7:0];
        end
        for (int i = 0; i < 256; i += 17) begin
            chk("period_repeat", {24'b0, rec[i + 256]}, {24'b0, rec[i]});
        end
        // Shadow write without commit must not alter the output.
        cfg(1'b0, 1'b0, 32'h0300_0000);
        run(40);

        // Randomised traffic: en gaps, wraps, commits, same-cycle wr+commit, sync_clr.
        repeat (400) begin
            en         = ($urandom_range(0, 3) != 0);
            sync_clr   = ($urandom_range(0, 30) == 0);
            cfg_wr     = ($urandom_range(0, 3) == 0);
            cfg_ch     = 1'($urandom);
            cfg_sel    = 1'($urandom);
            cfg_data   = $urandom;
            cfg_commit = ($urandom_range(0, 7) == 0);
            tick();
        end
        sync_clr = 1'b0; cfg_wr = 1'b0; cfg_commit = 1'b0;
        en = 1'b0;
        run(6);
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // Coherent restart: sync_clr together with commit.
        cfg(1'b0, 1'b1, 32'h0);
        cfg(1'b1, 1'b1, 32'h0);
        cfg(1'b0, 1'b0, 32'h0123_4567);
        cfg(1'b1, 1'b0, 32'h0765_4321);
        commit();
        en = 1'b1;
        run(10);
        cfg(1'b0, 1'b0, 32'h0200_0000);
        sync_clr = 1'b1; cfg_commit = 1'b1;
        tick();
        sync_clr = 1'b0; cfg_commit = 1'b0;
        run(4);
        chk("restart_phase0", {16'b0, da_data}, 32'h8080);
        run(20);

        // Asynchronous reset mid-run takes effect immediately.
        sys_rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_da", {16'b0, da_data}, 32'h8080);
        model_reset();
        run(2);
        sys_rst = 1'b0;
        run(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
